db15_serial_pad: RTL and testbench
==================================

Name: db15_serial_pad

Overview:
- Serial reader for the external DB15 joystick adapter on the open-drain user port.
- Produces two 16-bit, active-high joystick words that the top-level input mapping ORs with USB/keyboard controls before they reach the game core INP0/INP1/INP2 buses.
- Drives the adapter's LOAD and CLK lines and shifts in one bit per serial clock.
- Outputs update only on complete frames, so the game core never sees a torn sample.

Parameters:
- CLK_DIV, 24, clk_sys cycles per serial half-period (48 MHz / 48 = 1 MHz JOY_CLK).
- POLL_CYCLES, 48000, clk_sys cycles from the start of one frame to the start of the next (1 kHz poll rate).
- BITS_PER_PAD, 12, serial bits read per player.

Ports:
- clk_sys  in  1  system clock, 48 MHz.
- reset_n  in  1  reset.
- enable  in  1  1 = polling active (menu SNAC option not Off); 0 = finish current frame, then idle.
- JOY_DATA  in  1  serial data from the adapter, active-low (0 = pressed).
- JOY_CLK  out  1  serial clock to the adapter.
- JOY_LOAD  out  1  parallel-load strobe, active-low.
- joystick1  out  16  player 1 buttons, active-high; [11:0] valid, [15:12] = 0.
- joystick2  out  16  player 2 buttons, same layout.
- frame_done  out  1  one-cycle pulse when both joystick words are updated.

Interface note: Already decided — one clock (clk_sys); reset is asynchronous and active-low (reset_n).

Behaviour:
- Reset (reset_n = 0, asynchronous) forces:
  - JOY_CLK = 1, JOY_LOAD = 1, frame_done = 0, joystick1 = joystick2 = 16'h0000.
  - FSM to IDLE; all counters to 0.
- Divider tick: a 1-cycle tick every CLK_DIV clk_sys cycles while the FSM is not IDLE. It is reset to 0 on each entry to LOAD.
- Poll counter runs freely 0..POLL_CYCLES-1 and wraps. It does not depend on FSM state.
- IDLE: on poll counter == 0 with enable = 1 -> LOAD. With enable = 0, stay in IDLE; outputs hold their last values.
- LOAD:
  - JOY_LOAD = 0 for 2 ticks; JOY_CLK stays 1.
  - Then JOY_LOAD = 1, bit index = 0 -> SHIFT_LO.
- SHIFT_LO: JOY_CLK = 0 for 1 tick -> SHIFT_HI.
- SHIFT_HI:
  - On the tick where JOY_CLK rises 0 -> 1, sample JOY_DATA into shift[bit index].
  - Bit 0 is the bit presented after LOAD, before the first falling edge. Bits are sampled on rising edges only, so bit 0 is captured on the first rising edge.
  - JOY_CLK = 1 for 1 tick. If bit index == 2*BITS_PER_PAD-1 -> LATCH; otherwise increment bit index -> SHIFT_LO.
- LATCH (1 cycle):
  - joystick1[11:0] = ~shift[11:0].
  - joystick2[11:0] = ~shift[23:12].
  - frame_done = 1 for this cycle only; then -> IDLE.
- Bit order: serial bit n goes to pad bit n; shift bits 0..11 = player 1, bits 12..23 = player 2. Pad bit map: 0 right, 1 left, 2 down, 3 up, 4..11 buttons as wired on the adapter.
- Frame length: (2 + 2*2*BITS_PER_PAD) ticks. It must be less than POLL_CYCLES / CLK_DIV. Above that, the poll-counter-zero event is ignored while busy and the next frame starts on the following zero.
- enable dropping mid-frame: the frame completes and latches normally, then the FSM stays IDLE.
- JOY_DATA is double-flopped before sampling. The synchronizer latency of 2 cycles is far below CLK_DIV, so no timing adjustment is applied.
- Disconnected adapter (JOY_DATA pulled high): every frame latches all-zero words. No error flag is raised.

Decomposition:
- Shared package db15_pkg:
  - FSM state enum {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH}.
  - Pad bit-index constants (PAD_RIGHT = 0, PAD_LEFT = 1, PAD_DOWN = 2, PAD_UP = 3, PAD_B1 = 4, ...).
- One natural sub-module, db15_tick_gen: CLK_DIV divider with a synchronous restart input and a tick output. Everything else stays in the top-level FSM.

Test Plan:
- Reset release, enable = 1, JOY_DATA model returns 24'hFFFFFE (P1 bit 0 low) -> after the first frame_done: joystick1 = 16'h0001, joystick2 = 16'h0000; JOY_LOAD low exactly 2*CLK_DIV cycles; exactly 24 JOY_CLK rising edges.
- Model returns P1 = 12'h0F0 pressed, P2 = 12'h805 pressed -> joystick1 = 16'h00F0, joystick2 = 16'h0805; frame_done is 1 cycle wide; successive frame_done pulses are POLL_CYCLES cycles apart.
- enable deasserted at bit 10 of a frame -> frame completes, the new values latch, no further JOY_LOAD pulses; re-assert -> next LOAD starts at poll counter == 0.
- reset_n asserted mid-SHIFT (async, between clock edges) -> JOY_CLK = 1, JOY_LOAD = 1, joystick words = 0 immediately; the first frame after release is a full 24-bit frame.
- JOY_DATA held high (no adapter) for 5 frames -> both words stay 16'h0000, frame_done pulses 5 times.
- Pattern change between frames (model switches data after LOAD) -> outputs show only the old pattern or the new pattern, never a mix within one latch.

Source files
------------

// File: rtl/db15_pkg.sv
// Shared types and constants for the DB15 serial joystick reader.
// Pad bit map matches the adapter wiring: directions first, then buttons.
package db15_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } db15_state_e;

  localparam int PAD_RIGHT = 0;
  localparam int PAD_LEFT  = 1;
  localparam int PAD_DOWN  = 2;
  localparam int PAD_UP    = 3;
  localparam int PAD_B1    = 4;
  localparam int PAD_B2    = 5;
  localparam int PAD_B3    = 6;
  localparam int PAD_B4    = 7;
  localparam int PAD_B5    = 8;
  localparam int PAD_B6    = 9;
  localparam int PAD_B7    = 10;
  localparam int PAD_B8    = 11;

  localparam int PAD_WORD_W = 16;
  // Serial ticks JOY_LOAD is held low before shifting starts.
  localparam int LOAD_TICKS = 2;

endpackage

// File: rtl/db15_tick_gen.sv
// Serial half-period divider: one-cycle tick every CLK_DIV cycles,
// held at phase zero while restart is high.
module db15_tick_gen
  import db15_pkg::*;
#(
  parameter int CLK_DIV = 24
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)              cnt <= '0;
    else if (restart)          cnt <= '0;
    else if (cnt == CNT_LAST)  cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

  assign tick = !restart && (cnt == CNT_LAST);

endmodule

// File: rtl/db15_serial_pad.sv
// DB15 adapter reader: strobes LOAD, clocks out two pads' worth of bits and
// publishes both active-high joystick words together once per poll period.
module db15_serial_pad
  import db15_pkg::*;
#(
  parameter int CLK_DIV      = 24,
  parameter int POLL_CYCLES  = 48000,
  parameter int BITS_PER_PAD = 12
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  localparam int NBITS = 2 * BITS_PER_PAD;
  localparam int BW    = $clog2(NBITS);
  localparam int PW    = $clog2(POLL_CYCLES);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NBITS - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [1:0]    LOAD_LAST = 2'(LOAD_TICKS - 1);

  db15_state_e        state, state_nxt;
  logic [PW-1:0]      poll_cnt;
  logic [1:0]         data_s;
  logic [1:0]         load_cnt;
  logic [BW-1:0]      bit_idx;
  logic [NBITS-1:0]   shift;
  logic               tick;
  logic               last_bit;
  logic [15:0]        pad1_nxt, pad2_nxt;

  // Divider only runs in an active frame, so LOAD always starts at phase zero.
  db15_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .restart (state == IDLE),
    .tick    (tick)
  );

  // Free-running poll counter; frames start only on its zero.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                poll_cnt <= '0;
    else if (poll_cnt == POLL_LAST) poll_cnt <= '0;
    else                         poll_cnt <= poll_cnt + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) data_s <= 2'b11;
    else          data_s <= {data_s[0], JOY_DATA};
  end

  assign last_bit = (bit_idx == LAST_BIT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (poll_cnt == '0 && enable)     state_nxt = LOAD;
      LOAD:     if (tick && load_cnt == LOAD_LAST) state_nxt = SHIFT_LO;
      SHIFT_LO: if (tick)                          state_nxt = SHIFT_HI;
      SHIFT_HI: if (tick)                          state_nxt = last_bit ? LATCH : SHIFT_LO;
      LATCH:                                       state_nxt = IDLE;
      default:                                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      load_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      if (state != LOAD) load_cnt <= '0;
      else if (tick)     load_cnt <= load_cnt + 1'b1;

      if (state == LOAD)                        bit_idx <= '0;
      else if (state == SHIFT_HI && tick && !last_bit) bit_idx <= bit_idx + 1'b1;

      // The SHIFT_LO tick is the JOY_CLK rising edge.
      if (state == SHIFT_LO && tick) shift[bit_idx] <= data_s[1];
    end
  end

  // Adapter data is active-low; unused upper pad bits stay zero.
  always_comb begin
    pad1_nxt = '0;
    pad2_nxt = '0;
    for (int i = 0; i < BITS_PER_PAD; i++) begin
      pad1_nxt[i] = ~shift[i];
      pad2_nxt[i] = ~shift[BITS_PER_PAD + i];
    end
  end

  // Pad lines are registered from the next state so they stay glitch-free
  // yet line up cycle-for-cycle with the FSM state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      JOY_CLK    <= 1'b1;
      JOY_LOAD   <= 1'b1;
      frame_done <= 1'b0;
      joystick1  <= '0;
      joystick2  <= '0;
    end else begin
      JOY_CLK    <= (state_nxt != SHIFT_LO);
      JOY_LOAD   <= (state_nxt != LOAD);
      frame_done <= (state_nxt == LATCH);
      if (state_nxt == LATCH) begin
        joystick1 <= pad1_nxt;
        joystick2 <= pad2_nxt;
      end
    end
  end

endmodule

// File: tb/tb_db15_serial_pad.sv
// Bench for db15_serial_pad: a behavioural 24-bit parallel-load adapter model
// feeds random button patterns; expected words come from the pressed bits.
module tb_db15_serial_pad;

  localparam int CLK_DIV = 4;
  localparam int POLL    = 600;
  localparam int BPP     = 12;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b1;
  logic        joy_data;
  logic        joy_clk, joy_load, frame_done;
  logic [15:0] joystick1, joystick2;

  db15_serial_pad #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL), .BITS_PER_PAD(BPP)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .enable     (enable),
    .JOY_DATA   (joy_data),
    .JOY_CLK    (joy_clk),
    .JOY_LOAD   (joy_load),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_done (frame_done)
  );

  always #5 clk_sys = ~clk_sys;

  int passed = 0, total = 0;
  int cyc = 0, clk_rises = 0, load_pulses = 0, last_load_cyc = 0;
  int load_low = 0, done_pulses = 0, ref_load_cyc = 0;

  // Adapter model: pressed buttons are captured on LOAD, one bit per rising JOY_CLK.
  logic [23:0] pressed_next = 24'h000001;
  logic [23:0] loaded = '0;
  int          pos = 24;

  always @(negedge joy_load or posedge joy_clk) begin
    if (!joy_load) begin
      loaded = pressed_next;
      pos    = 0;
    end else begin
      pos = pos + 1;
    end
  end
  assign joy_data = (pos < 24) ? ~loaded[pos] : 1'b1;

  always @(posedge clk_sys) cyc = cyc + 1;
  always @(posedge joy_clk) if (reset_n) clk_rises = clk_rises + 1;
  always @(negedge joy_load) begin
    load_pulses   = load_pulses + 1;
    last_load_cyc = cyc;
  end
  always @(negedge clk_sys) begin
    if (reset_n && !joy_load) load_low = load_low + 1;
    if (frame_done === 1'b1)  done_pulses = done_pulses + 1;
  end

  function automatic logic [15:0] exp_pad(input logic [23:0] p, input int player);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < BPP; i++) w[i] = p[player*BPP + i];
    return w;
  endfunction

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3*POLL; i++) begin
      @(negedge clk_sys);
      if (frame_done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_load(input int limit, output bit ok);
    int n0;
    n0 = load_pulses;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_sys);
      if (load_pulses != n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    total++; if (joy_clk !== 1'b1) $display("FAIL rst_clk: got %b want 1", joy_clk); else passed++;
    total++; if (joy_load !== 1'b1) $display("FAIL rst_load: got %b want 1", joy_load); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL rst_done: got %b want 0", frame_done); else passed++;
    total++; if (joystick1 !== 16'h0000) $display("FAIL rst_j1: got %h want 0000", joystick1); else passed++;
    total++; if (joystick2 !== 16'h0000) $display("FAIL rst_j2: got %h want 0000", joystick2); else passed++;
  endtask

  task automatic test_first_frame();
    bit ok; int ll0, r0;
    pressed_next = 24'h000001;
    ll0 = load_low;
    reset_n = 1'b1;
    wait_load(4, ok);
    total++; if (!ok) $display("FAIL first_load: got no LOAD want LOAD after release"); else passed++;
    ref_load_cyc = last_load_cyc;
    r0 = clk_rises;
    wait_done(ok);
    total++; if (!ok) $display("FAIL first_done: got timeout want frame_done"); else passed++;
    total++; if (joystick1 !== 16'h0001) $display("FAIL first_j1: got %h want 0001", joystick1); else passed++;
    total++; if (joystick2 !== 16'h0000) $display("FAIL first_j2: got %h want 0000", joystick2); else passed++;
    total++; if (load_low - ll0 != 2*CLK_DIV) $display("FAIL load_width: got %0d want %0d", load_low - ll0, 2*CLK_DIV); else passed++;
    total++; if (clk_rises - r0 != 24) $display("FAIL clk_rises: got %0d want 24", clk_rises - r0); else passed++;
    @(negedge clk_sys);
    total++; if (frame_done !== 1'b0) $display("FAIL done_width: got %b want 0", frame_done); else passed++;
  endtask

  task automatic test_patterns();
    bit ok; int prev; logic [23:0] p;
    pressed_next = {12'h805, 12'h0F0};
    wait_done(ok);
    total++; if (!ok) $display("FAIL pat_done: got timeout want frame_done"); else passed++;
    total++; if (joystick1 !== 16'h00F0) $display("FAIL pat_j1: got %h want 00F0", joystick1); else passed++;
    total++; if (joystick2 !== 16'h0805) $display("FAIL pat_j2: got %h want 0805", joystick2); else passed++;
    prev = cyc;
    for (int k = 0; k < 4; k++) begin
      p = 24'($urandom);
      pressed_next = p;
      wait_done(ok);
      total++; if (!ok) $display("FAIL rnd_done: got timeout want frame_done"); else passed++;
      total++; if (joystick1 !== exp_pad(p, 0)) $display("FAIL rnd_j1: got %h want %h", joystick1, exp_pad(p, 0)); else passed++;
      total++; if (joystick2 !== exp_pad(p, 1)) $display("FAIL rnd_j2: got %h want %h", joystick2, exp_pad(p, 1)); else passed++;
      total++; if (cyc - prev != POLL) $display("FAIL done_spacing: got %0d want %0d", cyc - prev, POLL); else passed++;
      prev = cyc;
      @(negedge clk_sys);
      total++; if (frame_done !== 1'b0) $display("FAIL rnd_done_width: got %b want 0", frame_done); else passed++;
    end
  endtask

  task automatic test_enable_drop();
    bit ok; int r0, lp0; logic [23:0] p;
    p = 24'($urandom) | 24'h000100;
    pressed_next = p;
    wait_load(2*POLL, ok);
    total++; if (!ok) $display("FAIL en_load: got timeout want LOAD"); else passed++;
    r0 = clk_rises;
    for (int i = 0; i < 2*POLL; i++) begin
      if (clk_rises - r0 >= 10) break;
      @(negedge clk_sys);
    end
    enable = 1'b0;
    wait_done(ok);
    total++; if (!ok) $display("FAIL en_done: got timeout want frame_done"); else passed++;
    total++; if (joystick1 !== exp_pad(p, 0)) $display("FAIL en_j1: got %h want %h", joystick1, exp_pad(p, 0)); else passed++;
    total++; if (joystick2 !== exp_pad(p, 1)) $display("FAIL en_j2: got %h want %h", joystick2, exp_pad(p, 1)); else passed++;
    lp0 = load_pulses;
    pressed_next = ~p;
    repeat (3*POLL) @(negedge clk_sys);
    total++; if (load_pulses != lp0) $display("FAIL en_idle_loads: got %0d want %0d", load_pulses, lp0); else passed++;
    total++; if (joystick1 !== exp_pad(p, 0)) $display("FAIL en_hold_j1: got %h want %h", joystick1, exp_pad(p, 0)); else passed++;
    repeat ($urandom_range(1, POLL-1)) @(negedge clk_sys);
    p = 24'($urandom);
    pressed_next = p;
    enable = 1'b1;
    wait_load(2*POLL, ok);
    total++; if (!ok) $display("FAIL reen_load: got timeout want LOAD"); else passed++;
    total++; if ((last_load_cyc - ref_load_cyc) % POLL != 0)
      $display("FAIL reen_phase: got offset %0d want 0", (last_load_cyc - ref_load_cyc) % POLL); else passed++;
    wait_done(ok);
    total++; if (joystick2 !== exp_pad(p, 1)) $display("FAIL reen_j2: got %h want %h", joystick2, exp_pad(p, 1)); else passed++;
  endtask

  task automatic test_reset_mid_shift();
    bit ok; int r0; logic [23:0] p;
    pressed_next = 24'($urandom) | 24'h001001;
    wait_load(2*POLL, ok);
    repeat (60) @(negedge clk_sys);
    @(posedge clk_sys);
    #3 reset_n = 1'b0;
    #1;
    total++; if (joy_clk !== 1'b1) $display("FAIL async_clk: got %b want 1", joy_clk); else passed++;
    total++; if (joy_load !== 1'b1) $display("FAIL async_load: got %b want 1", joy_load); else passed++;
    total++; if (joystick1 !== 16'h0000) $display("FAIL async_j1: got %h want 0000", joystick1); else passed++;
    total++; if (joystick2 !== 16'h0000) $display("FAIL async_j2: got %h want 0000", joystick2); else passed++;
    repeat (3) @(negedge clk_sys);
    p = 24'($urandom);
    pressed_next = p;
    reset_n = 1'b1;
    wait_load(4, ok);
    total++; if (!ok) $display("FAIL rel_load: got no LOAD want LOAD after release"); else passed++;
    ref_load_cyc = last_load_cyc;
    r0 = clk_rises;
    wait_done(ok);
    total++; if (clk_rises - r0 != 24) $display("FAIL rel_rises: got %0d want 24", clk_rises - r0); else passed++;
    total++; if (joystick1 !== exp_pad(p, 0)) $display("FAIL rel_j1: got %h want %h", joystick1, exp_pad(p, 0)); else passed++;
    total++; if (joystick2 !== exp_pad(p, 1)) $display("FAIL rel_j2: got %h want %h", joystick2, exp_pad(p, 1)); else passed++;
  endtask

  task automatic test_no_adapter();
    bit ok; int d0;
    pressed_next = '0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    d0 = done_pulses;
    for (int k = 0; k < 5; k++) begin
      wait_done(ok);
      total++; if (!ok || joystick1 !== 16'h0000) $display("FAIL nc_j1: got %h want 0000", joystick1); else passed++;
      total++; if (!ok || joystick2 !== 16'h0000) $display("FAIL nc_j2: got %h want 0000", joystick2); else passed++;
    end
    @(negedge clk_sys);
    @(negedge clk_sys);
    total++; if (done_pulses - d0 != 5) $display("FAIL nc_pulses: got %0d want 5", done_pulses - d0); else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok; logic [23:0] p_old;
    pressed_next = 24'($urandom);
    for (int k = 0; k < 3; k++) begin
      p_old = pressed_next;
      wait_load(2*POLL, ok);
      total++; if (!ok) $display("FAIL b2b_load: got timeout want LOAD"); else passed++;
      pressed_next = 24'($urandom);
      wait_done(ok);
      total++; if (joystick1 !== exp_pad(p_old, 0)) $display("FAIL b2b_j1: got %h want %h", joystick1, exp_pad(p_old, 0)); else passed++;
      total++; if (joystick2 !== exp_pad(p_old, 1)) $display("FAIL b2b_j2: got %h want %h", joystick2, exp_pad(p_old, 1)); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_patterns();
    test_enable_drop();
    test_reset_mid_shift();
    test_no_adapter();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
